// File: rtl/freqdiv_ctrl.sv
// Frequency-divider sequencer: start/stop, ratio select (N = 2^(SEL+1)), boundary-aligned ratio switching.
// Optional macro FREQDIV_CTRL_CNT_EN adds PERIOD_CNT, a saturating count of DIV_STB pulses.
module freqdiv_ctrl #(
    parameter int SEL_W   = 2,
    parameter int RST_SEL = 2,
    parameter int CNT_W   = SEL_W + 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CFG_VALID,
    input  logic [SEL_W-1:0] CFG_SEL,
    output logic             CFG_READY,
    output logic [SEL_W-1:0] CUR_SEL,
    output logic             DIVCLK,
    output logic             DIV_STB,
`ifdef FREQDIV_CTRL_CNT_EN
    output logic             BUSY,
    output logic [15:0]      PERIOD_CNT
`else
    output logic             BUSY
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_SWITCH = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SEL_W-1:0]   cur_sel_r;
    logic [SEL_W-1:0]   sel_n;
    logic [SEL_W-1:0]   pend_sel_r;
    logic [SEL_W-1:0]   pend_n;
    logic               at_last;
    logic               hs;
    logic               swap_done;
    logic               divclk_r;
    logic               div_stb_r;
    logic               cfg_ready_r;
    logic               busy_r;

    // Terminal count N-1 for a given select: the low SEL+1 bits set.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [SEL_W-1:0] sel);
        logic [CNT_W-1:0] m;
        m = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (i <= int'(sel)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    assign hs      = CFG_VALID & cfg_ready_r;
    assign at_last = (cnt_r == last_cnt(cur_sel_r));
    assign cnt_inc = at_last ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));

    // Next-state, counter and select computation.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        sel_n     = cur_sel_r;
        pend_n    = pend_sel_r;
        swap_done = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_n = '0;
                if (hs) begin
                    sel_n = CFG_SEL;
                end else begin
                    sel_n = cur_sel_r;
                end
                if (EN) begin
                    state_n = S_RUN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_n = cnt_inc;
                // A real ratio change takes priority over EN falling.
                if (hs && (CFG_SEL != cur_sel_r)) begin
                    pend_n  = CFG_SEL;
                    state_n = S_SWITCH;
                end else if (!EN) begin
                    state_n = S_DRAIN;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_DRAIN: begin
                cnt_n = cnt_inc;
                if (at_last) begin
                    state_n = EN ? S_RUN : S_IDLE;
                end else begin
                    state_n = S_DRAIN;
                end
            end
            S_SWITCH: begin
                cnt_n = cnt_inc;
                if (at_last) begin
                    sel_n     = pend_sel_r;
                    swap_done = 1'b1;
                    state_n   = EN ? S_RUN : S_IDLE;
                end else begin
                    state_n = S_SWITCH;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // FSM state, counter and registered outputs derived from next-state values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            cur_sel_r   <= SEL_W'(RST_SEL);
            pend_sel_r  <= SEL_W'(RST_SEL);
            divclk_r    <= 1'b0;
            div_stb_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            cur_sel_r   <= sel_n;
            pend_sel_r  <= pend_n;
            divclk_r    <= cnt_n[sel_n];
            div_stb_r   <= (state_n != S_IDLE) && (cnt_n == last_cnt(sel_n));
            cfg_ready_r <= (state_n == S_IDLE) || (state_n == S_RUN);
            busy_r      <= (state_n == S_DRAIN) || (state_n == S_SWITCH);
        end
    end

    assign CFG_READY = cfg_ready_r;
    assign CUR_SEL   = cur_sel_r;
    assign DIVCLK    = divclk_r;
    assign DIV_STB   = div_stb_r;
    assign BUSY      = busy_r;

`ifdef FREQDIV_CTRL_CNT_EN
    logic [15:0] period_cnt_r;

    // Saturating strobe count; a completed switch starts a fresh count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            period_cnt_r <= 16'h0000;
        end else if (swap_done) begin
            period_cnt_r <= 16'h0000;
        end else if (div_stb_r && (period_cnt_r != 16'hFFFF)) begin
            period_cnt_r <= period_cnt_r + 16'h0001;
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end

    assign PERIOD_CNT = period_cnt_r;
`endif

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Scoreboard bench for freqdiv_ctrl: directed stimulus pushes hand-derived expectations, a negedge monitor checks them.
module tb_freqdiv_ctrl;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       CFG_VALID;
    logic [1:0] CFG_SEL;
    logic       CFG_READY;
    logic [1:0] CUR_SEL;
    logic       DIVCLK;
    logic       DIV_STB;
    logic       BUSY;
`ifdef FREQDIV_CTRL_CNT_EN
    logic [15:0] PERIOD_CNT;
`endif

    freqdiv_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .CFG_VALID (CFG_VALID),
        .CFG_SEL   (CFG_SEL),
        .CFG_READY (CFG_READY),
        .CUR_SEL   (CUR_SEL),
        .DIVCLK    (DIVCLK),
        .DIV_STB   (DIV_STB),
`ifdef FREQDIV_CTRL_CNT_EN
        .BUSY      (BUSY),
        .PERIOD_CNT(PERIOD_CNT)
`else
        .BUSY      (BUSY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {divclk, stb, ready, busy, sel}
    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t  sb_q[$];
    int    checks;
    int    errors;
    int    stb_count;
    string phase;

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2, ST_SWITCH = 3;

    // One clock: drive inputs, then after the edge queue the output vector expected for the state (cnt, sel, state).
    task automatic cyc(input logic r, input logic en, input logic vld, input logic [1:0] cs,
                       input int ecnt, input logic [1:0] esel, input int est);
        exp_t e;
        logic dclk, stb, rdy, bsy;
        RST       = r;
        EN        = en;
        CFG_VALID = vld;
        CFG_SEL   = cs;
        @(posedge CLK);
        dclk  = ((ecnt >> esel) & 1) != 0;
        stb   = (est != ST_IDLE) && (ecnt == ((2 << esel) - 1));
        rdy   = (est == ST_IDLE) || (est == ST_RUN);
        bsy   = (est == ST_DRAIN) || (est == ST_SWITCH);
        e.v   = {dclk, stb, rdy, bsy, esel};
        e.tag = phase;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        logic [5:0] act;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {DIVCLK, DIV_STB, CFG_READY, BUSY, CUR_SEL};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s t=%0t {divclk,stb,ready,busy,sel} act=%b exp=%b",
                         e.tag, $time, act, e.v);
            end
            if (DIV_STB === 1'b1) stb_count++;
        end
    end

    initial begin
        int wait_cnt;
        checks    = 0;
        errors    = 0;
        stb_count = 0;
        RST = 1'b1; EN = 1'b1; CFG_VALID = 1'b0; CFG_SEL = 2'd0;

        phase = "reset";
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 2'd2, ST_IDLE);

        phase = "div8_run";
        stb_count = 0;
        for (int j = 0; j < 2000; j++) cyc(1'b0, 1'b1, 1'b0, 2'd0, j % 8, 2'd2, ST_RUN);
        @(negedge CLK); #1;
        checks++;
        if (stb_count != 250) begin
            errors++;
            $display("FAIL div8_stb_count act=%0d exp=%0d", stb_count, 250);
        end

        phase = "switch_to_2";
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, k, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4, 2'd2, ST_SWITCH);
        for (int k = 5; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, k, 2'd2, ST_SWITCH);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, k % 2, 2'd0, ST_RUN);

        phase = "switch_at_last";
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 0, 2'd0, ST_SWITCH);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1, 2'd0, ST_SWITCH);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 0, 2'd2, ST_RUN);

        phase = "same_sel_noop";
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b1, 2'd2, 3, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 5, 2'd2, ST_RUN);

        phase = "drain";
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 6, 2'd2, ST_DRAIN);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 7, 2'd2, ST_DRAIN);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 0, 2'd2, ST_IDLE);

        phase = "idle_cfg";
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 0, 2'd1, ST_IDLE);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 0, 2'd2, ST_IDLE);

        phase = "drain_reenter";
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 0, 2'd2, ST_RUN);
        for (int k = 1; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, k, 2'd2, ST_RUN);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 6, 2'd2, ST_DRAIN);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 7, 2'd2, ST_DRAIN);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 0, 2'd2, ST_RUN);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1, 2'd2, ST_RUN);

        phase = "simultaneous";
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 2, 2'd2, ST_SWITCH);
        for (int k = 3; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, k, 2'd2, ST_SWITCH);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 0, 2'd3, ST_IDLE);

        phase = "reset_mid_switch";
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 0, 2'd3, ST_RUN);
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 1, 2'd3, ST_SWITCH);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 2, 2'd3, ST_SWITCH);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 0, 2'd2, ST_IDLE);
`ifdef FREQDIV_CTRL_CNT_EN
        checks++;
        if (PERIOD_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL period_cnt_reset act=%h exp=%h", PERIOD_CNT, 16'h0000);
        end
`endif
        phase = "after_reset";
        for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 1'b0, 2'd0, k % 8, 2'd2, ST_RUN);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(posedge CLK);
            wait_cnt++;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain act=%0d exp=%0d", sb_q.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freqdiv_ctrl.md
Name: freqdiv_ctrl

Overview:
Controller that sequences the frequency-divider chain under software/FSM control. It starts and stops the divider and selects the divide ratio (2/4/8/16). It switches ratio only at period boundaries, so the divided output never shows a truncated phase. It produces a registered divided clock and a one-cycle strobe, which downstream logic uses as a clock enable. It sits between the LAB3 control FSM (config handshake) and the divided-clock consumers.

Parameters:
SEL_W, 2, width of ratio select; divide ratio N = 2^(SEL+1)
RST_SEL, 2, ratio select loaded at reset (2 -> divide-by-8)
CNT_W, SEL_W+3, internal period counter width (covers N max = 2^(2^SEL_W))

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  run request (level)
CFG_VALID  input  1  new ratio offered
CFG_SEL  input  SEL_W  requested ratio select
CFG_READY  output  1  controller can accept a ratio this cycle
CUR_SEL  output  SEL_W  ratio currently in effect
DIVCLK  output  1  registered divided clock, 50% duty, period N
DIV_STB  output  1  one-cycle pulse, last cycle of each period
BUSY  output  1  high in DRAIN or SWITCH

Behaviour:
- Reset, and any cycle with RST=1 including mid-operation: state=IDLE, cnt=0, CUR_SEL=RST_SEL, DIVCLK=0, DIV_STB=0, CFG_READY=1, BUSY=0. RST overrides all other inputs.
- cnt counts 0..N-1 and wraps.
- DIVCLK = cnt[CUR_SEL], so it is low for cnt in [0, N/2-1] and high for [N/2, N-1]. It is taken directly from a flop and is glitch-free.
- DIV_STB = 1 exactly when state is RUN/DRAIN/SWITCH and cnt = N-1.
- States:
  - IDLE: cnt held at 0, DIVCLK=0, DIV_STB=0.
    - EN=1 -> RUN. The first RUN cycle has cnt=0.
    - A CFG handshake (CFG_VALID & CFG_READY) in IDLE loads CUR_SEL on the next edge. The state stays IDLE.
  - RUN: cnt increments every cycle. The first DIV_STB occurs in the N-th cycle of RUN (cnt=N-1).
    - EN=0 -> DRAIN.
    - Handshake with CFG_SEL != CUR_SEL: latch the pending select, drop CFG_READY, go to SWITCH.
    - Handshake with CFG_SEL == CUR_SEL: accepted as a no-op. CFG_READY stays 1 and counting is undisturbed.
  - DRAIN: keep counting until the cycle with cnt=N-1, then leave.
    - EN=1 in that cycle -> RUN with cnt=0 and no gap.
    - Otherwise -> IDLE.
    - CFG_READY=0.
  - SWITCH: keep counting under the old CUR_SEL until cnt=N-1 (old N). On that edge CUR_SEL <= pending select and cnt <= 0.
    - Then -> RUN if EN=1, else IDLE.
    - CFG_READY returns to 1 on entry to the next state.
- Simultaneous EN fall and handshake in RUN: SWITCH wins. At the boundary EN=0 sends the state to IDLE, and the new CUR_SEL is kept.
- If a ratio change lands exactly at cnt=N-1 in RUN, the current period still completes first. SWITCH then runs one full old-ratio period before loading the new select.
- CFG_VALID with CFG_READY=0 is ignored. The requester must hold CFG_VALID and CFG_SEL stable until it sees the handshake.
- Period lengths are always exactly N, with no short or long periods, except at the very first RUN entry, which has a full N period.

Optional Feature:
FREQDIV_CTRL_CNT_EN
- Defined: adds output PERIOD_CNT [15:0], which counts DIV_STB pulses. It saturates at 16'hFFFF and is cleared by RST and by every SWITCH completion.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset check: hold RST=1 for 3 cycles with EN=1 -> CUR_SEL=2, DIVCLK=0, DIV_STB=0, CFG_READY=1, BUSY=0 on every cycle.
2. Divide-by-8 run: release RST, raise EN -> DIV_STB at RUN cycles 7, 15, 23...; DIVCLK low for 4 cycles, high for 4; 250 periods in 2000 cycles.
3. Ratio switch: in RUN at cnt=3 (N=8), offer CFG_SEL=0 -> handshake the same cycle, BUSY=1, 4 more cycles at N=8. Then DIVCLK toggles every cycle (N=2), CUR_SEL=0, CFG_READY=1.
4. Drain: drop EN at cnt=5 (N=8) -> DIV_STB at cnt=7, then IDLE with DIVCLK=0. Re-raising EN at cnt=7 instead gives seamless RUN with no gap.
5. Simultaneous: EN falls in the same cycle as a CFG_SEL=3 handshake -> old period completes, CUR_SEL=3, state IDLE, no DIV_STB afterward.
6. Reset mid-SWITCH: assert RST while BUSY=1 -> next edge gives all reset values and CUR_SEL=RST_SEL. The pending select is discarded. With FREQDIV_CTRL_CNT_EN defined, PERIOD_CNT=0.
